// File: rtl/periph_bus_arbiter_pkg.sv
// Shared constants and types for the two-master peripheral bus arbiter.
package periph_bus_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int MAX_BIT_POS = XLEN - 1;

  typedef enum logic [1:0] {
    PBUS_ARB_IDLE = 2'd0,
    PBUS_ARB_BUSY = 2'd1,
    PBUS_ARB_DONE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [MAX_BIT_POS:0] addr;
    logic [MAX_BIT_POS:0] wdata;
    logic [1:0]           byte_size;
    logic                 write;
  } bus_req_t;

endpackage

// File: rtl/periph_bus_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone requester wins; on a tie the master not granted last time wins.
module pbus_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin front end for peripherals_bus; one transaction in flight at a time.
// Optional BUSY-cycle timeout abort is compiled in with PBUS_ARB_TIMEOUT_EN.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int              TIMEOUT_CYCLES = 1024,
  parameter logic [XLEN-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] m0_addr,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [1:0]      m0_byte_size,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_ready,
  output logic            m0_err,
  input  logic [XLEN-1:0] m1_addr,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [1:0]      m1_byte_size,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_ready,
  output logic            m1_err,
  output logic [XLEN-1:0] io_addr,
  output logic [XLEN-1:0] io_wdata,
  output logic            io_read,
  output logic            io_write,
  output logic [1:0]      io_byte_size,
  output logic            read_ready,
  input  logic [XLEN-1:0] io_rdata,
  input  logic            io_ready
);

  arb_state_t      state_reg, state_next;
  logic [1:0]      req;
  logic            grant, pick_valid;
  logic            owner_reg, last_grant_reg;
  bus_req_t        sel_req, io_req_reg;
  logic            io_read_reg, io_write_reg, read_ready_reg;
  logic [1:0]      ready_reg, err_reg;
  logic [XLEN-1:0] rdata_reg [2];
  logic            start, finish_ok, abort, timeout_hit;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  pbus_rr_pick u_pick (
    .req       (req),
    .last_grant(last_grant_reg),
    .grant     (grant),
    .valid     (pick_valid)
  );

  always_comb begin
    sel_req.addr      = grant ? m1_addr      : m0_addr;
    sel_req.wdata     = grant ? m1_wdata     : m0_wdata;
    sel_req.byte_size = grant ? m1_byte_size : m0_byte_size;
    sel_req.write     = grant ? m1_write     : m0_write;
  end

`ifdef PBUS_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_reg;

  // Counts consecutive BUSY cycles without io_ready; cleared whenever the bus is not waiting.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == PBUS_ARB_BUSY && !io_ready) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
    end else begin
      tmo_cnt_reg <= '0;
    end
  end

  assign timeout_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= PBUS_ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // io_ready is checked before the timeout so a same-cycle completion is never reported as an error.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    finish_ok  = 1'b0;
    abort      = 1'b0;
    unique case (state_reg)
      PBUS_ARB_IDLE: begin
        if (pick_valid) begin
          start      = 1'b1;
          state_next = PBUS_ARB_BUSY;
        end
      end
      PBUS_ARB_BUSY: begin
        if (io_ready) begin
          finish_ok  = 1'b1;
          state_next = PBUS_ARB_DONE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = PBUS_ARB_DONE;
        end
      end
      PBUS_ARB_DONE: state_next = PBUS_ARB_IDLE;
      default:       state_next = PBUS_ARB_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      io_req_reg     <= '0;
      io_read_reg    <= 1'b0;
      io_write_reg   <= 1'b0;
      read_ready_reg <= 1'b0;
      ready_reg      <= '0;
      err_reg        <= '0;
    end else begin
      read_ready_reg <= finish_ok;
      ready_reg      <= '0;
      err_reg        <= '0;
      if (start) begin
        owner_reg      <= grant;
        last_grant_reg <= grant;
        io_req_reg     <= sel_req;
        io_read_reg    <= ~sel_req.write;
        io_write_reg   <= sel_req.write;
      end
      if (finish_ok || abort) begin
        io_read_reg          <= 1'b0;
        io_write_reg         <= 1'b0;
        ready_reg[owner_reg] <= 1'b1;
        err_reg[owner_reg]   <= abort;
      end
    end
  end

  // Read data persists between transactions; write completions leave it alone.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '{default: '0};
    end else if (finish_ok && io_read_reg) begin
      rdata_reg[owner_reg] <= io_rdata;
    end else if (abort) begin
      rdata_reg[owner_reg] <= ERR_RDATA;
    end
  end

  assign io_addr      = io_req_reg.addr;
  assign io_wdata     = io_req_reg.wdata;
  assign io_byte_size = io_req_reg.byte_size;
  assign io_read      = io_read_reg;
  assign io_write     = io_write_reg;
  assign read_ready   = read_ready_reg;

  assign m0_rdata = rdata_reg[0];
  assign m0_ready = ready_reg[0];
  assign m0_err   = err_reg[0];
  assign m1_rdata = rdata_reg[1];
  assign m1_ready = ready_reg[1];
  assign m1_err   = err_reg[1];

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed cases then random traffic against a transaction-level model.
module tb_periph_bus_arbiter;
  import periph_bus_arbiter_pkg::*;

  localparam int TB_TMO = 8;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        m0_read, m0_write, m0_ready, m0_err, m1_read, m1_write, m1_ready, m1_err;
  logic [1:0]  m0_byte_size, m1_byte_size, io_byte_size;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        io_read, io_write, read_ready, io_ready;

  int total = 0;
  int bad   = 0;
  int rb;

  // Model: pending request per master, who wins the next tie, and each master's visible rdata.
  bit          pend  [2];
  bit          p_rd  [2];
  bit          p_wr  [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata[2];
  logic [1:0]  p_size [2];
  int          tie_m;
  logic [31:0] exp_rdata[2];

  periph_bus_arbiter #(.TIMEOUT_CYCLES(TB_TMO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_byte_size(m0_byte_size), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_byte_size(m1_byte_size), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_read(io_read), .io_write(io_write),
    .io_byte_size(io_byte_size), .read_ready(read_ready), .io_rdata(io_rdata), .io_ready(io_ready)
  );

  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic get_ready(input int m);
    return (m == 0) ? m0_ready : m1_ready;
  endfunction

  function automatic logic get_err(input int m);
    return (m == 0) ? m0_err : m1_err;
  endfunction

  task automatic drive();
    m0_read      = pend[0] && p_rd[0];
    m0_write     = pend[0] && p_wr[0];
    m0_addr      = p_addr[0];
    m0_wdata     = p_wdata[0];
    m0_byte_size = p_size[0];
    m1_read      = pend[1] && p_rd[1];
    m1_write     = pend[1] && p_wr[1];
    m1_addr      = p_addr[1];
    m1_wdata     = p_wdata[1];
    m1_byte_size = p_size[1];
  endtask

  // mode: 0 read, 1 write, 2 read+write (write expected to win)
  task automatic post(input int m, input int mode, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] s);
    pend[m]    = 1'b1;
    p_rd[m]    = (mode != 1);
    p_wr[m]    = (mode != 0);
    p_addr[m]  = a;
    p_wdata[m] = d;
    p_size[m]  = s;
  endtask

  // Called at a negedge while the arbiter is IDLE; returns at the negedge of the following IDLE cycle.
  task automatic txn(input int lat, input logic [31:0] data, input bit tmo, input bit keep);
    int w, o, hold_bad;
    bit wr;
    w = (pend[0] && pend[1]) ? tie_m : (pend[1] ? 1 : 0);
    o = 1 - w;
    tie_m = o;
    wr = p_wr[w];
    drive();
    $display("txn m%0d %s addr=%h lat=%0d tmo=%0d keep=%0d", w, wr ? "WR" : "RD", p_addr[w], lat, tmo, keep);
    @(negedge pclk);
    check_val("io_write", 32'(io_write), 32'(wr));
    check_val("io_read", 32'(io_read), 32'(!wr));
    check_val("io_addr", io_addr, p_addr[w]);
    check_val("io_wdata", io_wdata, p_wdata[w]);
    check_val("io_size", 32'(io_byte_size), 32'(p_size[w]));
    hold_bad = 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge pclk);
      if (io_write !== wr || io_read !== !wr || io_addr !== p_addr[w] || m0_ready !== 1'b0 || m1_ready !== 1'b0)
        hold_bad++;
    end
    check_val("busy_hold", hold_bad, 0);
    if (!tmo) begin
      io_ready = 1'b1;
      io_rdata = data;
    end
    @(negedge pclk);
    io_ready = 1'b0;
    io_rdata = $urandom();
    if (tmo) exp_rdata[w] = 32'hDEAD_BEEF;
    else if (!wr) exp_rdata[w] = data;
    check_val("own_ready", 32'(get_ready(w)), 1);
    check_val("own_err", 32'(get_err(w)), 32'(tmo));
    check_val("oth_ready_err", 32'(get_ready(o) | get_err(o)), 0);
    check_val("rdata0", m0_rdata, exp_rdata[0]);
    check_val("rdata1", m1_rdata, exp_rdata[1]);
    check_val("read_ready", 32'(read_ready), 32'(!tmo));
    check_val("io_drop", 32'(io_read | io_write), 0);
    if (!keep) begin
      pend[w] = 1'b0;
      drive();
    end
    @(negedge pclk);
    check_val("idle_gap", 32'({io_read, io_write, m0_ready, m1_ready, read_ready}), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    io_ready = 1'b0;
    tie_m = 0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
  endtask

  initial begin
    rst_n    = 1'b0;
    io_ready = 1'b0;
    io_rdata = '0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; p_rd[m] = 1'b0; p_wr[m] = 1'b0;
      p_addr[m] = '0; p_wdata[m] = '0; p_size[m] = '0;
      exp_rdata[m] = '0;
    end
    tie_m = 0;
    drive();
    repeat (2) @(negedge pclk);
    check_val("rst_io_read", 32'(io_read), 0);
    check_val("rst_io_write", 32'(io_write), 0);
    check_val("rst_io_addr", io_addr, 0);
    check_val("rst_ready", 32'({m0_ready, m1_ready, m0_err, m1_err, read_ready}), 0);
    check_val("rst_m0_rdata", m0_rdata, 0);
    check_val("rst_m1_rdata", m1_rdata, 0);
    rst_n = 1'b1;
    @(negedge pclk);

    // single m0 read, three BUSY wait cycles before io_ready
    post(0, 0, 32'h0000_0100, 32'h0, 2'd2);
    txn(3, 32'h1234_5678, 1'b0, 1'b0);

    // simultaneous requests after reset alternate m0, m1, m0
    do_reset();
    post(0, 0, 32'h0000_0200, 32'h0, 2'd2);
    post(1, 0, 32'h0000_0300, 32'h0, 2'd2);
    txn(1, 32'h1111_1111, 1'b0, 1'b0);
    post(0, 0, 32'h0000_0204, 32'h0, 2'd2);
    txn(0, 32'h2222_2222, 1'b0, 1'b0);
    post(1, 0, 32'h0000_0304, 32'h0, 2'd2);
    txn(2, 32'h3333_3333, 1'b0, 1'b0);
    txn(1, 32'h4444_4444, 1'b0, 1'b0);

    // m1 write completing on the first BUSY cycle
    post(1, 1, 32'h2000_0000, 32'hA5A5_A5A5, 2'd2);
    txn(0, 32'hFFFF_0000, 1'b0, 1'b0);

    // back-to-back m0 reads with the request held through completion
    post(0, 0, 32'h0000_0500, 32'h0, 2'd2);
    txn(1, 32'h5555_5555, 1'b0, 1'b1);
    txn(0, 32'h6666_6666, 1'b0, 1'b0);

    // slave that never answers
    post(0, 0, 32'h0000_0600, 32'h0, 2'd2);
`ifdef PBUS_ARB_TIMEOUT_EN
    txn(TB_TMO - 1, 32'h0, 1'b1, 1'b0);
`else
    txn(100, 32'hCAFE_F00D, 1'b0, 1'b0);
`endif

    // reset while BUSY
    post(0, 0, 32'h0000_0400, 32'h0, 2'd2);
    drive();
    @(negedge pclk);
    check_val("rst_pre_busy", 32'(io_read), 1);
    #2 rst_n = 1'b0;
    #1 check_val("rst_async_drop", 32'(io_read), 0);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive();
    rb = 0;
    repeat (3) begin
      @(negedge pclk);
      if ((m0_ready | m1_ready | m0_err | m1_err | read_ready) !== 1'b0) rb++;
    end
    check_val("rst_no_pulse", rb, 0);
    rst_n = 1'b1;
    tie_m = 0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    @(negedge pclk);
    post(0, 0, 32'h0000_0700, 32'h0, 2'd1);
    post(1, 0, 32'h0000_0800, 32'h0, 2'd1);
    txn(2, 32'h7777_7777, 1'b0, 1'b0);
    txn(0, 32'h8888_8888, 1'b0, 1'b0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) != 0)
          post(m, int'($urandom_range(0, 2)), $urandom(), $urandom(), 2'($urandom_range(0, 3)));
      end
      if (!pend[0] && !pend[1])
        post(int'($urandom_range(0, 1)), 0, $urandom(), $urandom(), 2'd2);
      txn(int'($urandom_range(0, 3)), $urandom(), 1'b0, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
